// File: rtl/fp_addsub_sequencer.sv
// Front-panel sequencer for the FP add/sub unit: turns ENTER edges into
// operand/result load pulses, launches the datapath and scans the display.
module fp_addsub_sequencer #(
   parameter int LAT      = 3,
   parameter int SCAN_DIV = 50000,
   parameter int DIGITS   = 4
) (
   input  logic                       clk_i,
   input  logic                       clr_i,
   input  logic                       enter_i,
   input  logic                       sub_i,
   output logic                       ld_a_o,
   output logic                       ld_b_o,
   output logic                       ld_r_o,
   output logic                       start_o,
   output logic                       op_sub_o,
   output logic                       busy_o,
   output logic [1:0]                 src_o,
   output logic [$clog2(DIGITS)-1:0]  dig_o,
   output logic [DIGITS-1:0]          an_o
);

   localparam int DW = $clog2(DIGITS);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [2:0] S_A    = 3'd0;
   localparam logic [2:0] S_LDA  = 3'd1;
   localparam logic [2:0] S_B    = 3'd2;
   localparam logic [2:0] S_LDB  = 3'd3;
   localparam logic [2:0] S_GO   = 3'd4;
   localparam logic [2:0] S_WAIT = 3'd5;
   localparam logic [2:0] S_LDR  = 3'd6;
   localparam logic [2:0] S_R    = 3'd7;

   logic [2:0]        state_q, state_d;
   logic [7:0]        wait_q, wait_d;
   logic              enter_q;
   logic              event_w;
   logic              op_sub_q, op_sub_d;
   logic              ld_a_q, ld_b_q, ld_r_q, start_q, busy_q;
   logic [1:0]        src_q, src_d;
   logic [SW-1:0]     scan_q, scan_d;
   logic [DW-1:0]     dig_q, dig_d;
   logic [DIGITS-1:0] an_q, an_d;

   assign event_w = enter_i & ~enter_q;

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      op_sub_d = op_sub_q;
      case (state_q)
         S_A:    if (event_w) state_d = S_LDA;
         S_LDA:  state_d = S_B;
         S_B: begin
            if (event_w) begin
               state_d  = S_LDB;
               op_sub_d = sub_i;
            end
         end
         S_LDB:  state_d = S_GO;
         S_GO: begin
            wait_d  = 8'(LAT - 1);
            state_d = (LAT == 1) ? S_LDR : S_WAIT;
         end
         // Leave when the decremented count hits zero so LD_R lands LAT cycles after START.
         S_WAIT: begin
            wait_d = wait_q - 8'd1;
            if (wait_q == 8'd1) state_d = S_LDR;
         end
         S_LDR:  state_d = S_R;
         S_R:    if (event_w) state_d = S_A;
         default: state_d = S_A;
      endcase
   end

   always_comb begin
      src_d = 2'd2;
      if (state_d == S_A || state_d == S_LDA) src_d = 2'd0;
      else if (state_d == S_B || state_d == S_LDB) src_d = 2'd1;
   end

   always_comb begin
      scan_d = scan_q + SW'(1);
      dig_d  = dig_q;
      if (scan_q == SW'(SCAN_DIV - 1)) begin
         scan_d = '0;
         dig_d  = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + DW'(1);
      end
   end

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
      assign an_d[gi] = (dig_d != DW'(gi));
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         state_q  <= S_A;
         wait_q   <= '0;
         enter_q  <= 1'b1;
         op_sub_q <= 1'b0;
         ld_a_q   <= 1'b0;
         ld_b_q   <= 1'b0;
         ld_r_q   <= 1'b0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         src_q    <= 2'd0;
         scan_q   <= '0;
         dig_q    <= '0;
         an_q     <= ~DIGITS'(1);
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         enter_q  <= enter_i;
         op_sub_q <= op_sub_d;
         ld_a_q   <= (state_d == S_LDA);
         ld_b_q   <= (state_d == S_LDB);
         ld_r_q   <= (state_d == S_LDR);
         start_q  <= (state_d == S_GO);
         busy_q   <= (state_d == S_GO) || (state_d == S_WAIT) || (state_d == S_LDR);
         src_q    <= src_d;
         scan_q   <= scan_d;
         dig_q    <= dig_d;
         an_q     <= an_d;
      end
   end

   assign ld_a_o   = ld_a_q;
   assign ld_b_o   = ld_b_q;
   assign ld_r_o   = ld_r_q;
   assign start_o  = start_q;
   assign op_sub_o = op_sub_q;
   assign busy_o   = busy_q;
   assign src_o    = src_q;
   assign dig_o    = dig_q;
   assign an_o     = an_q;

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Scoreboard bench for fp_addsub_sequencer: a phase-level model schedules
// expected pulses by cycle number; a negedge monitor pops and compares.
module tb_fp_addsub_sequencer;

   localparam int LAT      = 3;
   localparam int SCAN_DIV = 4;
   localparam int DIGITS   = 4;
   localparam int DW       = 2;

   localparam logic [3:0] P_A = 4'b1000;
   localparam logic [3:0] P_B = 4'b0100;
   localparam logic [3:0] P_S = 4'b0010;
   localparam logic [3:0] P_R = 4'b0001;

   logic              clk   = 1'b0;
   logic              clr   = 1'b1;
   logic              enter = 1'b1;
   logic              sub   = 1'b0;
   logic              ld_a, ld_b, ld_r, start, op_sub, busy;
   logic [1:0]        src;
   logic [DW-1:0]     dig;
   logic [DIGITS-1:0] an;

   fp_addsub_sequencer #(.LAT(LAT), .SCAN_DIV(SCAN_DIV), .DIGITS(DIGITS)) dut (
      .clk_i    (clk),
      .clr_i    (clr),
      .enter_i  (enter),
      .sub_i    (sub),
      .ld_a_o   (ld_a),
      .ld_b_o   (ld_b),
      .ld_r_o   (ld_r),
      .start_o  (start),
      .op_sub_o (op_sub),
      .busy_o   (busy),
      .src_o    (src),
      .dig_o    (dig),
      .an_o     (an)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] mask;
   } pulse_t;

   pulse_t sb[$];
   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   // Model: phase 0 = waiting for A, 1 = waiting for B, 2 = computing/showing R.
   int phase = 0, ready = 0;
   int src_old = 0, src_new = 0, src_chg = 0;
   int busy_lo = -1, busy_hi = -2, scan_base = 0;
   bit prev = 1'b1, armed = 1'b0, m_opsub = 1'b0;
   int exp_src = 0, exp_dig = 0;
   bit exp_busy = 1'b0;

   task automatic push(input int c, input logic [3:0] m);
      pulse_t p;
      p.cyc  = c;
      p.mask = m;
      sb.push_back(p);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h required %0h", name, cyc, got, exp);
      end
   endtask

   always @(posedge clk) begin : model
      int c;
      bit evt;
      c = cyc;
      if (clr) begin
         phase     = 0;
         ready     = 0;
         prev      = 1'b1;
         m_opsub   = 1'b0;
         src_old   = 0;
         src_new   = 0;
         src_chg   = 0;
         busy_lo   = -1;
         busy_hi   = -2;
         scan_base = c + 1;
         armed     = 1'b1;
         sb.delete();
      end else begin
         evt  = enter && !prev;
         prev = enter;
         if (evt && c >= ready) begin
            case (phase)
               0: begin
                  push(c + 1, P_A);
                  phase = 1; ready = c + 2;
                  src_old = 0; src_new = 1; src_chg = c + 2;
               end
               1: begin
                  push(c + 1, P_B);
                  push(c + 2, P_S);
                  push(c + 2 + LAT, P_R);
                  m_opsub = sub;
                  phase = 2; ready = c + 3 + LAT;
                  src_old = 1; src_new = 2; src_chg = c + 2;
                  busy_lo = c + 2; busy_hi = c + 2 + LAT;
               end
               default: begin
                  phase = 0; ready = c + 1;
                  src_old = 2; src_new = 0; src_chg = c + 1;
               end
            endcase
         end
      end
      cyc      = c + 1;
      exp_src  = (cyc >= src_chg) ? src_new : src_old;
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      exp_dig  = ((cyc - scan_base) / SCAN_DIV) % DIGITS;
   end

   always @(negedge clk) begin : monitor
      logic [3:0]        got;
      logic [DIGITS-1:0] exp_an;
      pulse_t            e;
      if (armed) begin
         got = {ld_a, ld_b, start, ld_r};
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if (got !== e.mask) begin
               errors++;
               $display("FAIL pulse cycle %0d: got a/b/start/r=%b required %b", cyc, got, e.mask);
            end else begin
               $display("cycle %0d: pulse a/b/start/r=%b op_sub=%b", cyc, got, op_sub);
            end
         end else if (got !== 4'b0000) begin
            checks++;
            errors++;
            $display("FAIL stray_pulse cycle %0d: got a/b/start/r=%b required 0000", cyc, got);
         end
         exp_an = ~(DIGITS'(1) << exp_dig);
         chk("src",    32'(src),    32'(exp_src));
         chk("busy",   32'(busy),   32'(exp_busy));
         chk("op_sub", 32'(op_sub), 32'(m_opsub));
         chk("dig",    32'(dig),    32'(exp_dig));
         chk("an",     32'(an),     32'(exp_an));
      end
   end

   task automatic run(input int n, input bit e, input bit s, input bit r);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         enter = e;
         sub   = s;
         clr   = r;
      end
   endtask

   initial begin
      // Reset with ENTER held through and past release.
      run(1, 1, 0, 1);
      run(2, 1, 0, 0);
      run(1, 0, 0, 0);
      // A at 5, B (subtract) at 10, presses during GO/WAIT, return at 30.
      run(1, 1, 0, 0);
      run(4, 0, 0, 0);
      run(1, 1, 1, 0);
      run(1, 0, 0, 0);
      run(1, 1, 0, 0);
      run(1, 0, 0, 0);
      run(1, 1, 0, 0);
      run(15, 0, 0, 0);
      run(1, 1, 0, 0);
      run(4, 0, 0, 0);
      // Held button in S_A: single LD_A.
      run(20, 1, 0, 0);
      run(3, 0, 0, 0);
      // B press then reset during WAIT: computation aborted.
      run(1, 1, 1, 0);
      run(3, 0, 0, 0);
      run(1, 0, 0, 1);
      run(5, 0, 0, 0);
      // Randomized button levels, operation select and occasional reset.
      for (int i = 0; i < 150; i++) begin
         run(1 + $urandom_range(0, 6), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 60) == 0));
      end
      run(LAT + 10, 0, 0, 0);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL pending_pulses: got %0d outstanding required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
